// File: rtl/ntt_lane_collector_if.sv
// ntt_lane_collector_if
//   Bundles the lane-side and output-side handshake signals of the NTT lane
//   collector.
//   Parameters: LANES (lane count), W (coefficient width).
//   Signals:
//     lane_data  [W*LANES]  lane i word in bits [i*W +: W]
//     lane_valid [LANES]    per-lane word valid
//     lane_ready [LANES]    per-lane accept (collector FIFO not full)
//     out_data   [W*LANES]  packed aligned vector, lane 0 in the low slice
//     out_valid             out_data holds a vector
//     out_ready             consumer accepts the vector
//   Modports: master = producer/consumer environment, slave = the collector.

`ifndef NTT_NUMBER
`define NTT_NUMBER 4
`endif
`ifndef DATA_SIZE_ARB
`define DATA_SIZE_ARB 27
`endif

interface ntt_lane_collector_if #(
    parameter int LANES = `NTT_NUMBER,
    parameter int W     = `DATA_SIZE_ARB
);
    logic [W*LANES-1:0] lane_data;
    logic [LANES-1:0]   lane_valid;
    logic [LANES-1:0]   lane_ready;
    logic [W*LANES-1:0] out_data;
    logic               out_valid;
    logic               out_ready;

    modport master (
        output lane_data, lane_valid, out_ready,
        input  lane_ready, out_data, out_valid
    );

    modport slave (
        input  lane_data, lane_valid, out_ready,
        output lane_ready, out_data, out_valid
    );
endinterface

// File: rtl/ntt_lane_collector.sv
// ntt_lane_collector
//   Aligns one coefficient from each of LANES parallel NTT lanes into a single
//   packed vector for the modular result adder. Each lane has its own circular
//   FIFO of DEPTH words; once every lane holds a word, the heads are captured
//   into the output register and all lanes pop together.
//
//   Parameters:
//     LANES  number of lanes / output slices
//     W      coefficient width
//     DEPTH  per-lane FIFO depth (power of two, >= 2)
//
//   Ports:
//     clk     rising-edge clock
//     rst_n   synchronous active-low reset
//     q_mod   modulus q, held stable while any FIFO is non-empty
//     flush   synchronous clear of all FIFOs and the output register
//     bus     ntt_lane_collector_if slave modport (lane and output handshakes)
//
//   Build option:
//     COLLECTOR_MOD_REDUCE_EN  when defined, each word x is stored in the output
//                              register as x - q_mod if x >= q_mod (unsigned,
//                              W bits); otherwise words pass through unchanged
//                              and q_mod is ignored.

`ifndef NTT_NUMBER
`define NTT_NUMBER 4
`endif
`ifndef DATA_SIZE_ARB
`define DATA_SIZE_ARB 27
`endif

module ntt_lane_collector #(
    parameter int LANES = `NTT_NUMBER,
    parameter int W     = `DATA_SIZE_ARB,
    parameter int DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [W-1:0]          q_mod,
    input  logic                  flush,
    ntt_lane_collector_if.slave   bus
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic               clear;
    logic [LANES-1:0]   lane_ready;
    logic [LANES-1:0]   lane_push;
    logic [LANES-1:0]   lane_avail;
    logic               all_avail;
    logic               load;
    logic [W*LANES-1:0] head_vec;
    logic [W*LANES-1:0] out_data_q;
    logic               out_valid_q;

    // Reset and flush share one clear path; reset simply wins by being ORed in.
    assign clear     = !rst_n || flush;
    assign all_avail = &lane_avail;
    assign load      = all_avail && (!out_valid_q || bus.out_ready);

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [W-1:0]    mem [DEPTH];
        logic [AW-1:0]   wr_ptr;
        logic [AW-1:0]   rd_ptr;
        logic [CW-1:0]   count;
        logic [W-1:0]    head;
        logic [W-1:0]    stored;

        // Ready comes from the registered count only, so out_ready never
        // reaches lane_ready combinationally.
        assign lane_ready[i] = (count != FULL);
        assign lane_avail[i] = (count != '0);
        assign lane_push[i]  = bus.lane_valid[i] && lane_ready[i];
        assign head          = mem[rd_ptr];

`ifdef COLLECTOR_MOD_REDUCE_EN
        assign stored = (head >= q_mod) ? (head - q_mod) : head;
`else
        assign stored = head;
`endif

        assign head_vec[i*W +: W] = stored;

        always_ff @(posedge clk) begin
            if (!clear && lane_push[i]) begin
                mem[wr_ptr] <= bus.lane_data[i*W +: W];
            end
        end

        always_ff @(posedge clk) begin
            if (clear) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (lane_push[i]) begin
                    wr_ptr <= wr_ptr + AW'(1);
                end
                if (load) begin
                    rd_ptr <= rd_ptr + AW'(1);
                end
                if (lane_push[i] && !load) begin
                    count <= count + CW'(1);
                end else if (!lane_push[i] && load) begin
                    count <= count - CW'(1);
                end
            end
        end
    end

`ifndef COLLECTOR_MOD_REDUCE_EN
    logic q_mod_unused;
    assign q_mod_unused = ^q_mod;
`endif

    always_ff @(posedge clk) begin
        if (clear) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else if (load) begin
            out_valid_q <= 1'b1;
            out_data_q  <= head_vec;
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.lane_ready = lane_ready;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_data   = out_data_q;

endmodule

// File: tb/tb_ntt_lane_collector.sv
// tb_ntt_lane_collector
//   Self-checking bench for ntt_lane_collector. A queue-based reference model
//   (per-lane word queues plus a one-slot output register) predicts lane_ready,
//   out_valid and out_data every cycle; directed steps add fixed-value checks.

module tb_ntt_lane_collector;

    localparam int LANES = 4;
    localparam int W     = 27;
    localparam int DEPTH = 4;
    localparam logic [W-1:0] Q = 27'h7FFF801;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         flush = 1'b0;
    logic [W-1:0] q_mod = Q;

    ntt_lane_collector_if #(.LANES(LANES), .W(W)) bus ();

    ntt_lane_collector #(.LANES(LANES), .W(W), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .q_mod (q_mod),
        .flush (flush),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // reference model state
    logic [W-1:0]       mq [LANES][$];
    bit                 m_ov = 1'b0;
    logic [W*LANES-1:0] m_od = '0;

    // DUT observations
    logic [W*LANES-1:0] dut_got [$];
    logic [LANES-1:0]   last_acc;
    logic               last_ov;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] red(input logic [W-1:0] x);
`ifdef COLLECTOR_MOD_REDUCE_EN
        return (x >= q_mod) ? x - q_mod : x;
`else
        return x;
`endif
    endfunction

    function automatic logic [W*LANES-1:0] vec4(input logic [W-1:0] l3, input logic [W-1:0] l2,
                                                input logic [W-1:0] l1, input logic [W-1:0] l0);
        return {l3, l2, l1, l0};
    endfunction

    // One clock: check outputs at the falling edge, then advance the model
    // with the inputs sampled at the rising edge.
    task automatic step();
        logic [LANES-1:0] rdy;
        bit               all_av;
        @(negedge clk);
        for (int i = 0; i < LANES; i++) rdy[i] = (mq[i].size() < DEPTH);
        chk("lane_ready", bus.lane_ready, rdy);
        chk("out_valid", bus.out_valid, m_ov);
        chk("out_data", bus.out_data, m_od);
        last_acc = bus.lane_valid & bus.lane_ready;
        last_ov  = bus.out_valid;
        if (bus.out_valid && bus.out_ready) dut_got.push_back(bus.out_data);
        @(posedge clk);
        if (!rst_n || flush) begin
            for (int i = 0; i < LANES; i++) mq[i].delete();
            m_ov = 1'b0;
            m_od = '0;
        end else begin
            all_av = 1'b1;
            for (int i = 0; i < LANES; i++) if (mq[i].size() == 0) all_av = 1'b0;
            if (all_av && (!m_ov || bus.out_ready)) begin
                for (int i = 0; i < LANES; i++) m_od[i*W +: W] = red(mq[i].pop_front());
                m_ov = 1'b1;
            end else if (m_ov && bus.out_ready) begin
                m_ov = 1'b0;
            end
            for (int i = 0; i < LANES; i++)
                if (bus.lane_valid[i] && rdy[i]) mq[i].push_back(bus.lane_data[i*W +: W]);
        end
        #1;
    endtask

    function automatic bit model_empty();
        for (int i = 0; i < LANES; i++) if (mq[i].size() != 0) return 1'b0;
        return !m_ov;
    endfunction

    // Streams n words per lane, honouring lane_ready, and compares the
    // delivered vectors against the expected aligned sequence.
    task automatic stream(input int n, input int hold, input bit rnd, input bit rdata, output int best);
        logic [W-1:0]       words [LANES][$];
        logic [W*LANES-1:0] expv [$];
        logic [W*LANES-1:0] v;
        logic [W-1:0]       w;
        int                 idx [LANES];
        int                 cyc = 0;
        int                 run = 0;
        bit                 done = 1'b0;
        best = 0;
        for (int k = 0; k < n; k++) begin
            for (int i = 0; i < LANES; i++) begin
                w = rdata ? W'($urandom_range(2 * Q - 1, 0)) : W'(k);
                words[i].push_back(w);
                v[i*W +: W] = red(w);
            end
            expv.push_back(v);
        end
        for (int i = 0; i < LANES; i++) idx[i] = 0;
        dut_got.delete();
        while (!done && cyc < 3000) begin
            for (int i = 0; i < LANES; i++) begin
                bus.lane_valid[i] = (idx[i] < n) && (!rnd || $urandom_range(3, 0) != 0);
                bus.lane_data[i*W +: W] = (idx[i] < n) ? words[i][idx[i]] : '0;
            end
            bus.out_ready = (cyc >= hold) && (!rnd || $urandom_range(1, 0) == 1);
            step();
            for (int i = 0; i < LANES; i++) if (last_acc[i]) idx[i]++;
            run  = last_ov ? run + 1 : 0;
            best = (run > best) ? run : best;
            if (hold > 0 && cyc == hold - 1) begin
                chk("bp_ready_low", bus.lane_ready, '0);
                chk("bp_hold_data", bus.out_data, expv[0]);
                chk("bp_hold_valid", bus.out_valid, 1'b1);
            end
            cyc++;
            done = 1'b1;
            for (int i = 0; i < LANES; i++) if (idx[i] < n) done = 1'b0;
            if (!model_empty()) done = 1'b0;
        end
        chk("stream_done", done, 1'b1);
        bus.lane_valid = '0;
        bus.out_ready  = 1'b1;
        step();
        step();
        chk("stream_count", dut_got.size(), n);
        for (int k = 0; k < n && k < dut_got.size(); k++) chk("stream_vec", dut_got[k], expv[k]);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int best;
        bus.lane_valid = '0;
        bus.lane_data  = '0;
        bus.out_ready  = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // reset state
        chk("rst_valid", bus.out_valid, 1'b0);
        chk("rst_data", bus.out_data, '0);
        chk("rst_ready", bus.lane_ready, 4'hF);
        step();

        // first vector and 1-cycle latency
        bus.lane_valid = 4'hF;
        bus.lane_data  = vec4(27'd4, 27'd3, Q + 27'd6, Q - 27'd1);
        step();
        bus.lane_valid = '0;
        chk("t1_not_yet", bus.out_valid, 1'b0);
        step();
        chk("t1_valid", bus.out_valid, 1'b1);
`ifdef COLLECTOR_MOD_REDUCE_EN
        chk("t1_data", bus.out_data, vec4(27'd4, 27'd3, 27'd6, Q - 27'd1));
`else
        chk("t1_data", bus.out_data, vec4(27'd4, 27'd3, Q + 27'd6, Q - 27'd1));
`endif
        bus.out_ready = 1'b1;
        step();
        step();

        // skewed arrival: lane 0 runs ahead until its FIFO fills
        dut_got.delete();
        for (int k = 1; k <= 5; k++) begin
            bus.lane_valid = 4'h1;
            bus.lane_data  = vec4('0, '0, '0, W'(k));
            step();
            if (k == 4) chk("skew_ready0_after4", bus.lane_ready[0], 1'b0);
        end
        chk("skew_ready0", bus.lane_ready[0], 1'b0);
        for (int k = 0; k < 4; k++) begin
            bus.lane_valid = 4'hE;
            bus.lane_data  = vec4(W'(10 + k), W'(10 + k), W'(10 + k), '0);
            step();
        end
        bus.lane_valid = '0;
        repeat (4) step();
        chk("skew_count", dut_got.size(), 4);
        for (int k = 0; k < 4 && k < dut_got.size(); k++)
            chk("skew_vec", dut_got[k], vec4(W'(10 + k), W'(10 + k), W'(10 + k), W'(k + 1)));
        chk("skew_idle_ready", bus.lane_ready, 4'hF);

        // backpressure: out_ready low for 10 cycles while streaming 0..7
        stream(8, 10, 1'b0, 1'b0, best);

        // full throughput
        stream(64, 0, 1'b0, 1'b1, best);
        chk("tput_run", best, 64);

        // mid-stream flush, then mid-stream reset
        for (int v = 0; v < 2; v++) begin
            bus.out_ready = 1'b0;
            for (int k = 0; k < 3; k++) begin
                bus.lane_valid = 4'hF;
                bus.lane_data  = vec4(W'(20 + k), W'(20 + k), W'(20 + k), W'(20 + k));
                step();
            end
            bus.lane_valid = '0;
            step();
            chk("fl_pre_valid", bus.out_valid, 1'b1);
            chk("fl_pre_ready", bus.lane_ready, 4'hF);
            if (v == 0) flush = 1'b1;
            else rst_n = 1'b0;
            bus.lane_valid = 4'hF;
            step();
            flush = 1'b0;
            rst_n = 1'b1;
            bus.lane_valid = '0;
            chk("fl_valid", bus.out_valid, 1'b0);
            chk("fl_ready", bus.lane_ready, 4'hF);
            chk("fl_data", bus.out_data, '0);
            dut_got.delete();
            bus.out_ready  = 1'b1;
            bus.lane_valid = 4'hF;
            bus.lane_data  = vec4(27'd9, 27'd9, 27'd9, 27'd9);
            step();
            bus.lane_valid = '0;
            repeat (3) step();
            chk("fl_count", dut_got.size(), 1);
            if (dut_got.size() > 0) chk("fl_vec", dut_got[0], vec4(27'd9, 27'd9, 27'd9, 27'd9));
        end

        // pointer wrap with random handshakes, then a longer random run
        stream(12, 0, 1'b1, 1'b1, best);
        stream(40, 0, 1'b1, 1'b1, best);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
